// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: sequences the BUFHCE CE from an enable request, enforcing dwell, drain and settle times.
// Latency: ce_out follows an eligible request by one cycle. Optional `CLK_GATE_STATS_EN adds gate_cnt.
module clk_gate_ctrl #(
  parameter int SETTLE_CYC = 4,
  parameter int DRAIN_CYC  = 2,
  parameter int MIN_ON     = 8,
  parameter int MIN_OFF    = 8,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic        force_on,
  output logic        ce_out,
  output logic        en_ack,
`ifdef CLK_GATE_STATS_EN
  output logic [15:0] gate_cnt,
`endif
  output logic        busy
);

  typedef enum logic [2:0] {
    S_OFF        = 3'd0,
    S_SETTLE_ON  = 3'd1,
    S_ON         = 3'd2,
    S_DRAIN      = 3'd3,
    S_SETTLE_OFF = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] L_SETTLE  = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] L_DRAIN   = CNT_W'(DRAIN_CYC);
  localparam logic [CNT_W-1:0] L_MIN_ON  = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] L_MIN_OFF = CNT_W'(MIN_OFF);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ce;
  logic             r_ack;
  logic             r_busy;
  logic             w_ce_nxt;
  logic             w_ack_nxt;
  logic             w_busy_nxt;
  logic             w_req;

  assign w_req = req_en | force_on;

  // Counter holds cycles spent in the current state, entry cycle counted as 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_OFF;
      r_cnt   <= L_MIN_OFF;
      r_ce    <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ce    <= w_ce_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= w_busy_nxt;
      if (w_state_nxt != r_state)
        r_cnt <= CNT_W'(1);
      else if (!(&r_cnt))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_OFF:        if (w_req && (r_cnt >= L_MIN_OFF)) w_state_nxt = S_SETTLE_ON;
      S_SETTLE_ON:  if (r_cnt >= L_SETTLE) w_state_nxt = S_ON;
      S_ON:         if (!w_req && (r_cnt >= L_MIN_ON))
                      w_state_nxt = (DRAIN_CYC == 0) ? S_SETTLE_OFF : S_DRAIN;
      S_DRAIN:      if (r_cnt >= L_DRAIN) w_state_nxt = S_SETTLE_OFF;
      S_SETTLE_OFF: if (r_cnt >= L_SETTLE) w_state_nxt = S_OFF;
      default:      w_state_nxt = S_OFF;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    w_ce_nxt   = 1'b0;
    w_ack_nxt  = 1'b0;
    w_busy_nxt = 1'b0;
    case (w_state_nxt)
      S_SETTLE_ON:  begin w_ce_nxt = 1'b1; w_busy_nxt = 1'b1; end
      S_ON:         begin w_ce_nxt = 1'b1; w_ack_nxt  = 1'b1; end
      S_DRAIN:      begin w_ce_nxt = 1'b1; w_busy_nxt = 1'b1; end
      S_SETTLE_OFF: w_busy_nxt = 1'b1;
      default:      w_ce_nxt = 1'b0;
    endcase
  end

  assign ce_out = r_ce;
  assign en_ack = r_ack;
  assign busy   = r_busy;

`ifdef CLK_GATE_STATS_EN
  logic [15:0] r_gate_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_gate_cnt <= 16'd0;
    else if ((r_state == S_SETTLE_ON) && (w_state_nxt == S_ON) && !(&r_gate_cnt))
      r_gate_cnt <= r_gate_cnt + 16'd1;
  end

  assign gate_cnt = r_gate_cnt;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Randomized bench for clk_gate_ctrl: a timestamp-based phase model feeds an expected-output queue
// that a negedge monitor drains against the DUT every cycle.
module tb_clk_gate_ctrl;
  localparam int SETTLE = 4;
  localparam int DRAIN  = 2;
  localparam int MON    = 8;
  localparam int MOFF   = 8;

  localparam int P_OFF = 0, P_SON = 1, P_ON = 2, P_DRAIN = 3, P_SOFF = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_en = 1'b0;
  logic force_on = 1'b0;
  logic ce_out, en_ack, busy;
`ifdef CLK_GATE_STATS_EN
  logic [15:0] gate_cnt;
`endif

  always #5 clk = ~clk;

  clk_gate_ctrl #(
    .SETTLE_CYC(SETTLE), .DRAIN_CYC(DRAIN), .MIN_ON(MON), .MIN_OFF(MOFF), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .req_en(req_en), .force_on(force_on),
    .ce_out(ce_out), .en_ack(en_ack),
`ifdef CLK_GATE_STATS_EN
    .gate_cnt(gate_cnt),
`endif
    .busy(busy)
  );

  typedef struct {
    logic        ce;
    logic        ack;
    logic        bsy;
    logic [15:0] gc;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase plus the absolute cycle it was entered; dwell = now - entry + 1.
  int cyc = 0;
  int ph = P_OFF;
  int entry = 0;
  int gcnt = 0;

  task automatic step(input logic r, input logic rq, input logic fo);
    int   dwell;
    int   np;
    logic eff;
    exp_t e;
    @(negedge clk);
    rst = r; req_en = rq; force_on = fo;
    @(posedge clk);
    if (r) begin
      ph = P_OFF;
      entry = cyc + 1 - MOFF;
      gcnt = 0;
    end else begin
      dwell = cyc - entry + 1;
      eff = rq | fo;
      np = ph;
      case (ph)
        P_OFF:   if (eff && dwell >= MOFF) np = P_SON;
        P_SON:   if (dwell >= SETTLE) np = P_ON;
        P_ON:    if (!eff && dwell >= MON) np = (DRAIN == 0) ? P_SOFF : P_DRAIN;
        P_DRAIN: if (dwell >= DRAIN) np = P_SOFF;
        default: if (dwell >= SETTLE) np = P_OFF;
      endcase
      if (np != ph) begin
        if (ph == P_SON && gcnt < 65535) gcnt++;
        ph = np;
        entry = cyc + 1;
      end
    end
    cyc++;
    e.ce  = (ph == P_SON || ph == P_ON || ph == P_DRAIN);
    e.ack = (ph == P_ON);
    e.bsy = (ph == P_SON || ph == P_DRAIN || ph == P_SOFF);
    e.gc  = 16'(gcnt);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [15:0] got_gc;
    if (q.size() > 0) begin
      e = q.pop_front();
      got_gc = e.gc;
`ifdef CLK_GATE_STATS_EN
      got_gc = gate_cnt;
`endif
      n_tests++;
      if (ce_out !== e.ce || en_ack !== e.ack || busy !== e.bsy || got_gc !== e.gc) begin
        n_fail++;
        $display("FAIL outs t=%0t: got ce=%b ack=%b busy=%b gc=%0d, expected ce=%b ack=%b busy=%b gc=%0d",
                 $time, ce_out, en_ack, busy, got_gc, e.ce, e.ack, e.bsy, e.gc);
      end
    end
  end

  initial begin
    int len;
    logic lvl;
    logic fo;
    int wait_cyc;

    repeat (3) step(1'b1, 1'b0, 1'b0);

    // Request at cycle 0, drop at 7, re-request at 19
    repeat (7)  step(1'b0, 1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0);
    repeat (30) step(1'b0, 1'b1, 1'b0);

    // One-cycle drop while ON and MIN_ON satisfied: DRAIN must run to OFF
    step(1'b0, 1'b0, 1'b0);
    repeat (30) step(1'b0, 1'b1, 1'b0);

    // Reset mid-DRAIN, then an immediate request
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b1, 1'b0);
    repeat (25) step(1'b0, 1'b0, 1'b0);

    // Short pulse right after reset
    step(1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0, 1'b0);

    // force_on alone, then release
    repeat (20) step(1'b0, 1'b0, 1'b1);
    repeat (25) step(1'b0, 1'b0, 1'b0);

    // Random segments: short pulses and long holds, occasional reset
    repeat (400) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 6);
      lvl = 1'($urandom_range(0, 1));
      fo  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) step(1'b1, lvl, fo);
      repeat (len) step(1'b0, lvl, fo);
    end

    repeat (2) step(1'b0, 1'b0, 1'b0);
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected outputs left unchecked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
